// File: rtl/speck_pkg.sv
// Shared SPECK 64/128 constants and the FSM state encoding, common to key_schedule and speck_encrypt.
package speck_pkg;

  localparam int WORD_W        = 32;
  localparam int ALPHA         = 8;
  localparam int BETA          = 3;
  localparam int ROUNDS_64_128 = 27;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ROUND = 4'd1,
    ST_DONE  = 4'd2
  } state_t;

endpackage

// File: rtl/speck_round.sv
// Combinational SPECK round: x' = (ROR(x,ALPHA) + y) ^ k, y' = ROL(y,BETA) ^ x'.
module speck_round
  import speck_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] k,
  output logic [WORD_W-1:0] x_n,
  output logic [WORD_W-1:0] y_n
);

  logic [WORD_W-1:0] x_ror;
  logic [WORD_W-1:0] y_rol;

  assign x_ror = {x[ALPHA-1:0], x[WORD_W-1:ALPHA]};
  assign y_rol = {y[WORD_W-BETA-1:0], y[WORD_W-1:WORD_W-BETA]};
  assign x_n   = (x_ror + y) ^ k;
  assign y_n   = y_rol ^ x_n;

endmodule

// File: rtl/speck_encrypt.sv
// Iterative SPECK 64/128 encryptor, one round per clock with on-the-fly key expansion.
// Optional debug port state_response is enabled by defining SPECK_STATE_RESPONSE_EN.
module speck_encrypt
  import speck_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_64_128
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         signal_start,
  input  logic [127:0] key,
  input  logic [63:0]  plaintext,
  output logic [63:0]  ciphertext,
  output logic         busy,
  output logic         finished
`ifdef SPECK_STATE_RESPONSE_EN
  ,
  output logic [3:0]   state_response
`endif
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [4:0]        cnt_q;
  logic [WORD_W-1:0] x_q, y_q, k_q, l0_q, l1_q, l2_q;
  logic [WORD_W-1:0] x_n, y_n, l_n, k_n;
  logic              load;
  logic              last;

  speck_round u_data (
    .x   (x_q),
    .y   (y_q),
    .k   (k_q),
    .x_n (x_n),
    .y_n (y_n)
  );

  // Key expansion reuses the round function with (l0, k, i) as (x, y, k).
  speck_round u_key (
    .x   (l0_q),
    .y   (k_q),
    .k   ({{(WORD_W-5){1'b0}}, cnt_q}),
    .x_n (l_n),
    .y_n (k_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (signal_start) begin
          load    = 1'b1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (cnt_q == LAST_RND) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (signal_start) begin
          load    = 1'b1;
          state_d = ST_ROUND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      k_q        <= '0;
      l0_q       <= '0;
      l1_q       <= '0;
      l2_q       <= '0;
      ciphertext <= '0;
      finished   <= 1'b0;
    end else begin
      finished <= last;
      if (last) ciphertext <= {x_n, y_n};
      if (load) begin
        cnt_q <= '0;
        x_q   <= plaintext[63:32];
        y_q   <= plaintext[31:0];
        k_q   <= key[31:0];
        l0_q  <= key[63:32];
        l1_q  <= key[95:64];
        l2_q  <= key[127:96];
      end else if (state_q == ST_ROUND) begin
        // Data uses the current k; the key state advances in the same cycle.
        cnt_q <= cnt_q + 5'd1;
        x_q   <= x_n;
        y_q   <= y_n;
        k_q   <= k_n;
        l0_q  <= l1_q;
        l1_q  <= l2_q;
        l2_q  <= l_n;
      end
    end
  end

  assign busy = (state_q == ST_ROUND);

`ifdef SPECK_STATE_RESPONSE_EN
  assign state_response = state_q;
`endif

endmodule

// File: tb/tb_speck_encrypt.sv
// Self-checking bench for speck_encrypt: known-answer, handshake corner cases and random vectors vs a reference model.
module tb_speck_encrypt;

  localparam int R = 27;
  localparam logic [127:0] KAT_KEY = 128'h1b1a1918131211100b0a090803020100;
  localparam logic [63:0]  KAT_PT  = 64'h3b7265747475432d;
  localparam logic [63:0]  KAT_CT  = 64'h8c6fa548454e028b;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         signal_start;
  logic [127:0] key;
  logic [63:0]  plaintext;
  logic [63:0]  ciphertext;
  logic         busy;
  logic         finished;
`ifdef SPECK_STATE_RESPONSE_EN
  logic [3:0]   state_response;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  speck_encrypt #(.ROUNDS(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signal_start (signal_start),
    .key          (key),
    .plaintext    (plaintext),
    .ciphertext   (ciphertext),
    .busy         (busy),
    .finished     (finished)
`ifdef SPECK_STATE_RESPONSE_EN
    ,
    .state_response (state_response)
`endif
  );

  function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Textbook SPECK: expand the whole key schedule into arrays, then encrypt.
  function automatic logic [63:0] speck_ref(input logic [127:0] k_in, input logic [63:0] p_in, input int rounds);
    logic [31:0] l [0:40];
    logic [31:0] k [0:40];
    logic [31:0] x, y;
    k[0] = k_in[31:0];
    l[0] = k_in[63:32];
    l[1] = k_in[95:64];
    l[2] = k_in[127:96];
    for (int i = 0; i < rounds - 1; i++) begin
      l[i+3] = (ror32(l[i], 8) + k[i]) ^ 32'(i);
      k[i+1] = rol32(k[i], 3) ^ l[i+3];
    end
    x = p_in[63:32];
    y = p_in[31:0];
    for (int i = 0; i < rounds; i++) begin
      x = (ror32(x, 8) + y) ^ k[i];
      y = rol32(y, 3) ^ x;
    end
    return {x, y};
  endfunction

  // Leaves the bench 1 time unit after the start edge E0.
  task automatic do_start(input logic [127:0] k, input logic [63:0] p);
    @(negedge clk);
    key          = k;
    plaintext    = p;
    signal_start = 1'b1;
    @(posedge clk);
    #1;
    signal_start = 1'b0;
  endtask

  task automatic wait_fin(output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (finished) break;
    end
  endtask

  // mode 1: second start at cycle 5; mode 2: inputs to all-ones from cycle 1.
  task automatic run_loop(input int mode, output int pulses, output int fcyc, output logic [63:0] ct);
    pulses = 0;
    fcyc   = 0;
    ct     = '0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      signal_start = (mode == 1 && c == 5);
      if (mode == 1 && c == 5) plaintext = 64'h0123456789abcdef;
      if (mode == 2 && c == 1) begin
        key       = '1;
        plaintext = '1;
      end
      @(posedge clk);
      #1;
      signal_start = 1'b0;
      if (finished) begin
        pulses++;
        fcyc = c;
        ct   = ciphertext;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (ciphertext !== 64'h0 || busy !== 1'b0 || finished !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ct=%h busy=%b fin=%b, required 0/0/0", ciphertext, busy, finished);
    end
`ifdef SPECK_STATE_RESPONSE_EN
    tests++;
    if (state_response !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d, required 0", state_response);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_kat;
    int cyc;
    do_start(KAT_KEY, KAT_PT);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL kat_busy_after_start: got %b, required 1", busy);
    end
    wait_fin(cyc);
    tests++;
    if (cyc != R) begin
      fails++;
      $display("FAIL kat_latency: got %0d cycles, required %0d", cyc, R);
    end
    tests++;
    if (ciphertext !== KAT_CT) begin
      fails++;
      $display("FAIL kat_ciphertext: got %h, required %h", ciphertext, KAT_CT);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL kat_busy_at_done: got %b, required 0", busy);
    end
    @(posedge clk);
    #1;
    tests++;
    if (finished !== 1'b0 || ciphertext !== KAT_CT) begin
      fails++;
      $display("FAIL kat_hold: fin=%b ct=%h, required 0/%h", finished, ciphertext, KAT_CT);
    end
  endtask

`ifdef SPECK_STATE_RESPONSE_EN
  task automatic test_state_response;
    int n;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (state_response !== 4'd0) begin
      fails++;
      $display("FAIL state_idle: got %0d, required 0", state_response);
    end
    do_start(KAT_KEY, KAT_PT);
    n = 0;
    while (state_response == 4'd1 && n < 60) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (n != R) begin
      fails++;
      $display("FAIL state_round_len: got %0d cycles, required %0d", n, R);
    end
    tests++;
    if (state_response !== 4'd2) begin
      fails++;
      $display("FAIL state_done: got %0d, required 2", state_response);
    end
    @(posedge clk);
    #1;
    tests++;
    if (state_response !== 4'd0) begin
      fails++;
      $display("FAIL state_back_idle: got %0d, required 0", state_response);
    end
  endtask
`endif

  task automatic test_ignore_start;
    int pulses, fcyc;
    logic [63:0] ct;
    do_start(KAT_KEY, KAT_PT);
    run_loop(1, pulses, fcyc, ct);
    tests++;
    if (pulses != 1 || fcyc != R || ct !== KAT_CT) begin
      fails++;
      $display("FAIL ignore_start: pulses=%0d at=%0d ct=%h, required 1/%0d/%h", pulses, fcyc, ct, R, KAT_CT);
    end
  endtask

  task automatic test_capture;
    int pulses, fcyc;
    logic [63:0] ct;
    do_start(KAT_KEY, KAT_PT);
    run_loop(2, pulses, fcyc, ct);
    tests++;
    if (pulses != 1 || fcyc != R || ct !== KAT_CT) begin
      fails++;
      $display("FAIL input_capture: pulses=%0d at=%0d ct=%h, required 1/%0d/%h", pulses, fcyc, ct, R, KAT_CT);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, pulses;
    do_start(KAT_KEY, KAT_PT);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ciphertext !== 64'h0 || busy !== 1'b0 || finished !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: ct=%h busy=%b fin=%b, required 0/0/0", ciphertext, busy, finished);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (finished) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_mid_no_finish: got %0d pulses, required 0", pulses);
    end
    do_start(KAT_KEY, KAT_PT);
    wait_fin(cyc);
    tests++;
    if (cyc != R || ciphertext !== KAT_CT) begin
      fails++;
      $display("FAIL reset_mid_restart: cyc=%0d ct=%h, required %0d/%h", cyc, ciphertext, R, KAT_CT);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bad_hold;
    logic [63:0] exp2;
    exp2 = speck_ref(128'h0, 64'h0, R);
    do_start(KAT_KEY, KAT_PT);
    wait_fin(cyc);
    do_start(128'h0, 64'h0);
    tests++;
    if (finished !== 1'b0 || ciphertext !== KAT_CT) begin
      fails++;
      $display("FAIL b2b_first_pulse: fin=%b ct=%h, required 0/%h", finished, ciphertext, KAT_CT);
    end
    bad_hold = 0;
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (finished) break;
      if (ciphertext !== KAT_CT) bad_hold++;
    end
    tests++;
    if (cyc != R || bad_hold != 0) begin
      fails++;
      $display("FAIL b2b_timing: cyc=%0d hold_errors=%0d, required %0d/0", cyc, bad_hold, R);
    end
    tests++;
    if (ciphertext !== exp2) begin
      fails++;
      $display("FAIL b2b_ciphertext: got %h, required %h", ciphertext, exp2);
    end
    @(posedge clk);
    #1;
    tests++;
    if (finished !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_pulse: got %b, required 0", finished);
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [127:0] k;
    logic [63:0]  p, exp;
    for (int n = 0; n < 10; n++) begin
      k   = {$urandom, $urandom, $urandom, $urandom};
      p   = {$urandom, $urandom};
      exp = speck_ref(k, p, R);
      do_start(k, p);
      wait_fin(cyc);
      tests++;
      if (cyc != R || ciphertext !== exp) begin
        fails++;
        $display("FAIL random_%0d: cyc=%0d ct=%h, required %0d/%h", n, cyc, ciphertext, R, exp);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    signal_start = 1'b0;
    key          = '0;
    plaintext    = '0;
    test_reset();
    test_kat();
`ifdef SPECK_STATE_RESPONSE_EN
    test_state_response();
`endif
    test_ignore_start();
    test_capture();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
